uart_tx_drain: RTL and testbench

//  UART transmitter that drains the 8-bit TX FIFO and serialises each byte as 8N1 (or 8N2) on tx.

---
 rtl/uart_tx_drain_pkg.sv | 13 +
 rtl/uart_baud_gen.sv | 53 +++++
 rtl/uart_tx_drain.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_drain.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_drain_pkg.sv
// Shared definitions for the UART TX drain block: FSM state encoding and frame width.
package uart_tx_drain_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: down-counter that captures the divisor at frame start and
// pulses o_bit_tick in the final cycle of every bit period.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_run,
  output logic                 o_bit_tick,
  output logic [DIV_WIDTH-1:0] o_cnt_nxt
);

  logic [DIV_WIDTH-1:0] r_div_q;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic                 w_zero;

  assign w_zero     = (r_cnt == {DIV_WIDTH{1'b0}});
  assign o_bit_tick = i_run && w_zero;
  assign o_cnt_nxt  = w_cnt_nxt;

  // Next count: load at frame start, reload on each bit boundary, else count down.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = i_div;
    end else if (i_run) begin
      if (w_zero) begin
        w_cnt_nxt = r_div_q;
      end else begin
        w_cnt_nxt = r_cnt - DIV_WIDTH'(1'b1);
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Counter and latched divisor registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= {DIV_WIDTH{1'b0}};
      r_div_q <= {DIV_WIDTH{1'b0}};
    end else begin
      r_cnt <= w_cnt_nxt;
      if (i_load) begin
        r_div_q <= i_div;
      end
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter draining a TX FIFO: pops one byte per frame and serialises it
// as start bit, LSB-first data and STOP_BITS stop bits on o_tx.
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DIV_WIDTH  = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [DIV_WIDTH-1:0]  i_baud_div,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_dout,
  output logic                  o_fifo_rd_en,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int              CNT_W     = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]      w_bit_cnt_nxt;
  logic [1:0]            r_stop_cnt;
  logic [1:0]            w_stop_cnt_nxt;

  logic                  r_tx;
  logic                  r_rd_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_tx_nxt;
  logic                  w_rd_en_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;

  logic                  w_start;
  logic                  w_run;
  logic                  w_tick;
  logic [DIV_WIDTH-1:0]  w_cnt_nxt;

  assign w_start = (r_state == ST_IDLE) && i_enable && !i_fifo_empty;
  assign w_run   = (r_state != ST_IDLE);

  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_gen (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_start),
    .i_div      (i_baud_div),
    .i_run      (w_run),
    .o_bit_tick (w_tick),
    .o_cnt_nxt  (w_cnt_nxt)
  );

  // State, shift register and bit/stop counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= {DATA_WIDTH{1'b0}};
      r_bit_cnt  <= {CNT_W{1'b0}};
      r_stop_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
    end
  end

  // Next-state logic; the shifter advances one bit per bit tick.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_START;
          w_shift_nxt = i_fifo_dout;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt   = ST_DATA;
          w_bit_cnt_nxt = {CNT_W{1'b0}};
          w_shift_nxt   = {1'b0, r_shift[DATA_WIDTH-1:1]};
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt    = ST_STOP;
            w_stop_cnt_nxt = 2'd0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1'b1);
            w_shift_nxt   = {1'b0, r_shift[DATA_WIDTH-1:1]};
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_stop_cnt == LAST_STOP) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_stop_cnt_nxt = r_stop_cnt + 2'd1;
          end
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs; tx_done marks the final stop-bit cycle.
  always_comb begin
    w_tx_nxt    = 1'b1;
    w_rd_en_nxt = 1'b0;
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_done_nxt  = (w_state_nxt == ST_STOP) && (w_cnt_nxt == {DIV_WIDTH{1'b0}}) &&
                  (w_stop_cnt_nxt == LAST_STOP);
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_tx_nxt    = 1'b0;
          w_rd_en_nxt = 1'b1;
        end else begin
          w_tx_nxt    = 1'b1;
          w_rd_en_nxt = 1'b0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_tx_nxt = r_shift[0];
        end else begin
          w_tx_nxt = 1'b0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_tx_nxt = 1'b1;
          end else begin
            w_tx_nxt = r_shift[0];
          end
        end else begin
          w_tx_nxt = r_tx;
        end
      end
      ST_STOP: begin
        w_tx_nxt = 1'b1;
      end
      default: begin
        w_tx_nxt = 1'b1;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx    <= 1'b1;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tx    <= w_tx_nxt;
      r_rd_en <= w_rd_en_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_tx         = r_tx;
  assign o_fifo_rd_en = r_rd_en;
  assign o_busy       = r_busy;
  assign o_tx_done    = r_done;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Randomised bench for uart_tx_drain: two instances (1 and 2 stop bits) fed from
// bench FIFOs and compared every cycle against a frame-position reference model.
module tb_uart_tx_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] baud_div;
  logic        empty0, empty1;
  logic [7:0]  dout0, dout1;
  logic        rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  uart_tx_drain #(.DATA_WIDTH(8), .DIV_WIDTH(16), .STOP_BITS(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_baud_div(baud_div),
    .i_fifo_empty(empty0), .i_fifo_dout(dout0), .o_fifo_rd_en(rd0),
    .o_tx(tx0), .o_busy(busy0), .o_tx_done(done0)
  );

  uart_tx_drain #(.DATA_WIDTH(8), .DIV_WIDTH(16), .STOP_BITS(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_baud_div(baud_div),
    .i_fifo_empty(empty1), .i_fifo_dout(dout1), .o_fifo_rd_en(rd1),
    .o_tx(tx1), .o_busy(busy1), .o_tx_done(done1)
  );

  logic [7:0] fq0[$];
  logic [7:0] fq1[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: position within the current frame (-1 = idle).
  int         m_pos[2];
  int         m_len[2];
  int         m_div[2];
  logic [7:0] m_byte[2];
  bit         m_rd[2];
  int         stop_bits[2] = '{1, 2};
  bit         rd_pre[2];
  int         last_pop[2];
  int         prev_pop[2];

  task automatic check_val(input string tag, input int obs, input int expv);
    n_vec++;
    if (obs != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int exp_tx(input int k);
    int bi;
    if (m_pos[k] < 0) return 1;
    bi = m_pos[k] / (m_div[k] + 1);
    if (bi == 0) return 0;
    if (bi <= 8) return int'(m_byte[k][bi-1]);
    return 1;
  endfunction

  task automatic model_step(input int k, input bit has_data, input logic [7:0] head);
    if (!rst_n) begin
      m_pos[k] = -1;
      m_rd[k]  = 1'b0;
    end else if (m_pos[k] >= 0) begin
      m_rd[k]  = 1'b0;
      m_pos[k] = (m_pos[k] + 1 < m_len[k]) ? m_pos[k] + 1 : -1;
    end else if (enable && has_data) begin
      m_byte[k] = head;
      m_div[k]  = int'(baud_div);
      m_len[k]  = (9 + stop_bits[k]) * (m_div[k] + 1);
      m_pos[k]  = 0;
      m_rd[k]   = 1'b1;
    end else begin
      m_rd[k] = 1'b0;
    end
  endtask

  task automatic compare(input int k, input logic tx, input logic busy,
                         input logic rd, input logic done);
    check_val($sformatf("tx%0d", k),    int'(tx),   exp_tx(k));
    check_val($sformatf("busy%0d", k),  int'(busy), (m_pos[k] >= 0) ? 1 : 0);
    check_val($sformatf("rd_en%0d", k), int'(rd),   int'(m_rd[k]));
    check_val($sformatf("done%0d", k),  int'(done),
              (m_pos[k] >= 0 && m_pos[k] == m_len[k] - 1) ? 1 : 0);
    if (rd === 1'b1) begin
      prev_pop[k] = last_pop[k];
      last_pop[k] = cyc;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    empty0 = (fq0.size() == 0);
    dout0  = empty0 ? 8'h00 : fq0[0];
    empty1 = (fq1.size() == 0);
    dout1  = empty1 ? 8'h00 : fq1[0];
    rd_pre[0] = rd0;
    rd_pre[1] = rd1;
    @(posedge clk);
    model_step(0, !empty0, dout0);
    model_step(1, !empty1, dout1);
    if (rd_pre[0] && fq0.size() > 0) void'(fq0.pop_front());
    if (rd_pre[1] && fq1.size() > 0) void'(fq1.pop_front());
    #1;
    cyc++;
    compare(0, tx0, busy0, rd0, done0);
    compare(1, tx1, busy1, rd1, done1);
  endtask

  task automatic push_both(input logic [7:0] b);
    fq0.push_back(b);
    fq1.push_back(b);
  endtask

  initial begin
    logic [7:0] rb;
    rst_n = 1'b0; enable = 1'b0; baud_div = 16'd0;
    empty0 = 1'b1; empty1 = 1'b1; dout0 = 8'h00; dout1 = 8'h00;
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = -1; m_len[k] = 0; m_div[k] = 0; m_byte[k] = 8'h00; m_rd[k] = 1'b0;
      last_pop[k] = 0; prev_pop[k] = 0;
    end
    repeat (3) cycle();
    rst_n = 1'b1;

    // Single byte 0xA5 at baud_div=3
    baud_div = 16'd3; push_both(8'hA5); enable = 1'b1;
    repeat (50) cycle();
    check_val("t1_fifo0_left", fq0.size(), 0);
    check_val("t1_fifo1_left", fq1.size(), 0);

    // Back-to-back frames with a single idle cycle between them
    baud_div = 16'd1; push_both(8'h00); push_both(8'hFF);
    repeat (60) cycle();
    check_val("t2_pop_gap0", last_pop[0] - prev_pop[0], 21);
    check_val("t2_pop_gap1", last_pop[1] - prev_pop[1], 23);
    check_val("t2_fifo0_left", fq0.size(), 0);
    check_val("t2_fifo1_left", fq1.size(), 0);

    // Idle: empty FIFO with enable, then data present with enable low
    repeat (100) cycle();
    enable = 1'b0; push_both(8'h5A);
    repeat (100) cycle();
    check_val("t3_fifo0_kept", fq0.size(), 1);
    check_val("t3_fifo1_kept", fq1.size(), 1);
    fq0.delete(); fq1.delete();

    // Enable drop during data bits of 0x3C with a second byte queued
    baud_div = 16'd2; push_both(8'h3C); push_both(8'h99); enable = 1'b1;
    repeat (10) cycle();
    enable = 1'b0;
    repeat (60) cycle();
    check_val("t4_fifo0_kept", fq0.size(), 1);
    check_val("t4_fifo1_kept", fq1.size(), 1);
    fq0.delete(); fq1.delete();

    // Reset for one cycle around bit 4 of 0x55, then restart from the FIFO
    baud_div = 16'd3; push_both(8'h55); push_both(8'h0F); enable = 1'b1;
    repeat (22) cycle();
    rst_n = 1'b0;
    cycle();
    check_val("t5_tx_after_rst", int'(tx0), 1);
    check_val("t5_busy_after_rst", int'(busy1), 0);
    rst_n = 1'b1;
    repeat (60) cycle();
    check_val("t5_fifo0_left", fq0.size(), 0);
    check_val("t5_fifo1_left", fq1.size(), 0);

    // baud_div=0 frames, divisor change mid-frame applies to the next frame only
    baud_div = 16'd0; push_both(8'h81); push_both(8'h42);
    repeat (4) cycle();
    baud_div = 16'd7;
    repeat (120) cycle();
    check_val("t6_fifo0_left", fq0.size(), 0);
    check_val("t6_fifo1_left", fq1.size(), 0);

    // Random traffic: pushes, enable toggles, divisor changes, rare resets
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 3) == 0 && fq0.size() < 3) begin
        rb = 8'($urandom());
        push_both(rb);
      end
      if ($urandom_range(0, 29) == 0) enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) baud_div = 16'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 249) != 0);
      cycle();
    end
    rst_n = 1'b1;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
